config_load_sequencer: RTL and testbench

//  Sequences writes into the transparent-latch configuration bank (32b data bus, one enable per word).

---
 rtl/config_load_sequencer_pkg.sv | 25 ++
 rtl/config_load_sequencer_if.sv | 31 +++
 rtl/config_load_sequencer_onehot_dec.sv | 18 +
 rtl/config_load_sequencer.sv | 131 +++++++++++++
 tb/tb_config_load_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/config_load_sequencer_pkg.sv
// Shared types and defaults for the config latch load sequencer.
package cfg_pkg;

  localparam int unsigned CFG_WORD_W  = 32;
  localparam int unsigned CFG_N_WORDS = 17;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } cfg_state_e;

  // Width of the shared phase down-counter: must hold max(*_CYC) - 1.
  function automatic int unsigned cfg_phase_w(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/config_load_sequencer_if.sv
// Command, config-word stream and latch-bank signals of the load sequencer.
interface config_load_sequencer_if
  import cfg_pkg::*;
#(
  parameter int unsigned WORD_W  = CFG_WORD_W,
  parameter int unsigned N_WORDS = CFG_N_WORDS,
  parameter int unsigned IDX_W   = 5
);
  logic               io_start;
  logic [IDX_W-1:0]   io_base;
  logic [IDX_W:0]     io_count;
  logic               io_abort;
  logic               io_in_valid;
  logic               io_in_ready;
  logic [WORD_W-1:0]  io_in_bits;
  logic [WORD_W-1:0]  io_d_out;
  logic [N_WORDS-1:0] io_configs_en;
  logic               io_busy;
  logic               io_done;
  logic               io_err;

  modport master (
    output io_start, io_base, io_count, io_abort, io_in_valid, io_in_bits,
    input  io_in_ready, io_d_out, io_configs_en, io_busy, io_done, io_err
  );

  modport slave (
    input  io_start, io_base, io_count, io_abort, io_in_valid, io_in_bits,
    output io_in_ready, io_d_out, io_configs_en, io_busy, io_done, io_err
  );
endinterface

// File: rtl/config_load_sequencer_onehot_dec.sv
// Word index to one-hot latch enable; all-zero when disabled or out of range.
module cfg_onehot_dec
  import cfg_pkg::*;
#(
  parameter int unsigned N_WORDS = CFG_N_WORDS,
  parameter int unsigned IDX_W   = 5
) (
  input  logic [IDX_W-1:0]   idx,
  input  logic               en,
  output logic [N_WORDS-1:0] onehot
);
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < N_WORDS; i++) begin
      if (en && (idx == IDX_W'(i))) onehot[i] = 1'b1;
    end
  end
endmodule

// File: rtl/config_load_sequencer.sv
// Sequences config words onto the shared latch data bus with setup/strobe/hold
// phasing so the data bus never changes while an enable is high.
module config_load_sequencer
  import cfg_pkg::*;
#(
  parameter int unsigned WORD_W     = CFG_WORD_W,
  parameter int unsigned N_WORDS    = CFG_N_WORDS,
  parameter int unsigned IDX_W      = 5,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 1,
  parameter int unsigned HOLD_CYC   = 1
) (
  input logic                    clk,
  input logic                    reset,
  config_load_sequencer_if.slave bus
);
  localparam int unsigned PH_W = cfg_phase_w(SETUP_CYC, STROBE_CYC, HOLD_CYC);

  cfg_state_e         state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W:0]     remaining;
  logic [PH_W-1:0]    phase_cnt;
  logic               aborted;
  logic [N_WORDS-1:0] dec_onehot;
  logic [IDX_W+1:0]   cmd_end;
  logic               cmd_ok;

  assign cmd_end = {2'b00, bus.io_base} + {1'b0, bus.io_count};
  assign cmd_ok  = (bus.io_count != '0) && (cmd_end <= (IDX_W+2)'(N_WORDS));

  // Abort outranks a pending word, so ready is masked by it.
  assign bus.io_in_ready = (state == WAIT) && !bus.io_abort;

  cfg_onehot_dec #(
    .N_WORDS(N_WORDS),
    .IDX_W  (IDX_W)
  ) u_dec (
    .idx   (idx),
    .en    (state == SETUP),
    .onehot(dec_onehot)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      idx               <= '0;
      remaining         <= '0;
      phase_cnt         <= '0;
      aborted           <= 1'b0;
      bus.io_d_out      <= '0;
      bus.io_configs_en <= '0;
      bus.io_busy       <= 1'b0;
      bus.io_done       <= 1'b0;
      bus.io_err        <= 1'b0;
    end else begin
      bus.io_done <= 1'b0;
      bus.io_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.io_start) begin
            if (cmd_ok) begin
              idx         <= bus.io_base;
              remaining   <= bus.io_count;
              aborted     <= 1'b0;
              bus.io_busy <= 1'b1;
              state       <= WAIT;
            end else begin
              bus.io_err <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (bus.io_abort) begin
            bus.io_busy <= 1'b0;
            state       <= IDLE;
          end else if (bus.io_in_valid) begin
            bus.io_d_out <= bus.io_in_bits;
            phase_cnt    <= PH_W'(SETUP_CYC - 1);
            state        <= SETUP;
          end
        end
        SETUP: begin
          if (bus.io_abort) begin
            bus.io_busy <= 1'b0;
            state       <= IDLE;
          end else if (phase_cnt == '0) begin
            bus.io_configs_en <= dec_onehot;
            phase_cnt         <= PH_W'(STROBE_CYC - 1);
            state             <= STROBE;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        STROBE: begin
          // An abort cuts the strobe short but still runs a full hold.
          if (bus.io_abort) aborted <= 1'b1;
          if (bus.io_abort || (phase_cnt == '0)) begin
            bus.io_configs_en <= '0;
            phase_cnt         <= PH_W'(HOLD_CYC - 1);
            state             <= HOLD;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (bus.io_abort) aborted <= 1'b1;
          if (phase_cnt == '0) begin
            idx       <= idx + 1'b1;
            remaining <= remaining - 1'b1;
            if (aborted || bus.io_abort) begin
              bus.io_busy <= 1'b0;
              state       <= IDLE;
            end else if (remaining == (IDX_W+1)'(1)) begin
              bus.io_done <= 1'b1;
              state       <= DONE;
            end else begin
              state <= WAIT;
            end
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        DONE: begin
          bus.io_busy <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_config_load_sequencer.sv
// Bench for config_load_sequencer: default-phase and stretched-phase instances
// checked every cycle against a time-window model plus directed expectations.
module tb_config_load_sequencer;
  localparam int NW = 17;
  localparam int S_B = 2, T_B = 3, H_B = 2;

  logic clk;
  logic rst;

  logic        start_i[2];
  logic [4:0]  base_i[2];
  logic [5:0]  count_i[2];
  logic        abort_i[2];
  logic        valid_i[2];
  logic [31:0] bits_i[2];

  logic        ready_o[2];
  logic [31:0] d_o[2];
  logic [16:0] en_o[2];
  logic        busy_o[2];
  logic        done_o[2];
  logic        err_o[2];

  config_load_sequencer_if #(.WORD_W(32), .N_WORDS(17), .IDX_W(5)) if_a ();
  config_load_sequencer_if #(.WORD_W(32), .N_WORDS(17), .IDX_W(5)) if_b ();

  config_load_sequencer #(
    .WORD_W(32), .N_WORDS(17), .IDX_W(5),
    .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)
  ) dut_a (.clk(clk), .reset(rst), .bus(if_a));

  config_load_sequencer #(
    .WORD_W(32), .N_WORDS(17), .IDX_W(5),
    .SETUP_CYC(S_B), .STROBE_CYC(T_B), .HOLD_CYC(H_B)
  ) dut_b (.clk(clk), .reset(rst), .bus(if_b));

  assign if_a.io_start = start_i[0];  assign if_b.io_start = start_i[1];
  assign if_a.io_base = base_i[0];    assign if_b.io_base = base_i[1];
  assign if_a.io_count = count_i[0];  assign if_b.io_count = count_i[1];
  assign if_a.io_abort = abort_i[0];  assign if_b.io_abort = abort_i[1];
  assign if_a.io_in_valid = valid_i[0]; assign if_b.io_in_valid = valid_i[1];
  assign if_a.io_in_bits = bits_i[0]; assign if_b.io_in_bits = bits_i[1];
  assign ready_o[0] = if_a.io_in_ready;  assign ready_o[1] = if_b.io_in_ready;
  assign d_o[0] = if_a.io_d_out;         assign d_o[1] = if_b.io_d_out;
  assign en_o[0] = if_a.io_configs_en;   assign en_o[1] = if_b.io_configs_en;
  assign busy_o[0] = if_a.io_busy;       assign busy_o[1] = if_b.io_busy;
  assign done_o[0] = if_a.io_done;       assign done_o[1] = if_b.io_done;
  assign err_o[0] = if_a.io_err;         assign err_o[1] = if_b.io_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: t counts cycles since the current word was accepted (-1 = waiting).
  // Setup occupies t<S, strobe S<=t<S+T, hold S+T<=t<S+T+H.
  typedef struct packed {
    bit          busy;
    bit          fin;
    bit          abrt;
    bit          err;
    int          t;
    int          idx;
    int          left;
    logic [31:0] d;
  } model_t;

  model_t m[2];

  function automatic int s_of(int k); return (k == 0) ? 1 : S_B; endfunction
  function automatic int t_of(int k); return (k == 0) ? 1 : T_B; endfunction
  function automatic int h_of(int k); return (k == 0) ? 1 : H_B; endfunction

  function automatic model_t m_reset();
    model_t r;
    r = '0;
    r.t = -1;
    return r;
  endfunction

  function automatic model_t step(model_t c, int s, int tt, int h, bit st, int b, int cnt,
                                  bit ab, bit v, logic [31:0] w);
    model_t n;
    n = c;
    n.err = 1'b0;
    if (!c.busy) begin
      if (st) begin
        if (cnt != 0 && b + cnt <= NW) begin
          n.busy = 1'b1; n.fin = 1'b0; n.abrt = 1'b0;
          n.t = -1; n.idx = b; n.left = cnt;
        end else n.err = 1'b1;
      end
    end else if (c.fin) begin
      n.busy = 1'b0; n.fin = 1'b0;
    end else if (c.t < 0) begin
      if (ab) n.busy = 1'b0;
      else if (v) begin n.d = w; n.t = 0; end
    end else if (c.t < s) begin
      if (ab) begin n.busy = 1'b0; n.t = -1; end
      else n.t = c.t + 1;
    end else if (c.t < s + tt) begin
      if (ab) begin n.abrt = 1'b1; n.t = s + tt; end
      else n.t = c.t + 1;
    end else begin
      n.abrt = c.abrt | ab;
      n.t = c.t + 1;
      if (n.t == s + tt + h) begin
        n.t = -1; n.idx = c.idx + 1; n.left = c.left - 1;
        if (n.abrt) n.busy = 1'b0;
        else if (n.left == 0) n.fin = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) m[k] <= m_reset();
      else m[k] <= step(m[k], s_of(k), t_of(k), h_of(k), start_i[k], int'(base_i[k]),
                        int'(count_i[k]), abort_i[k], valid_i[k], bits_i[k]);
    end
  end

  int total = 0;
  int bad = 0;
  int cyc_no = 0;
  int start_cyc = 0;
  int hi_cnt[2][17];
  int first_hi[2][17];
  logic [31:0] d_at[2][17];
  logic [16:0] en_mask[2];
  int done_cnt[2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_cmp();
    for (int k = 0; k < 2; k++) begin
      logic [16:0] e_en;
      e_en = '0;
      if (m[k].busy && m[k].t >= s_of(k) && m[k].t < s_of(k) + t_of(k)) e_en[m[k].idx] = 1'b1;
      chk($sformatf("m%0d_en", k), 64'(en_o[k]), 64'(e_en));
      chk($sformatf("m%0d_d", k), 64'(d_o[k]), 64'(m[k].d));
      chk($sformatf("m%0d_busy", k), 64'(busy_o[k]), 64'(m[k].busy));
      chk($sformatf("m%0d_done", k), 64'(done_o[k]), 64'(m[k].fin));
      chk($sformatf("m%0d_err", k), 64'(err_o[k]), 64'(m[k].err));
      chk($sformatf("m%0d_ready", k), 64'(ready_o[k]),
          64'(m[k].busy && !m[k].fin && m[k].t < 0 && !abort_i[k]));
    end
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      en_mask[k] = '0;
      done_cnt[k] = 0;
      for (int i = 0; i < NW; i++) begin
        hi_cnt[k][i] = 0; first_hi[k][i] = -1; d_at[k][i] = '0;
      end
    end
  endtask

  // One clock: model check at the falling edge, then sample just after the rise.
  task automatic cyc();
    @(negedge clk);
    model_cmp();
    @(posedge clk);
    #1;
    cyc_no++;
    for (int k = 0; k < 2; k++) begin
      en_mask[k] = en_mask[k] | en_o[k];
      if (done_o[k]) done_cnt[k]++;
      for (int i = 0; i < NW; i++) begin
        if (en_o[k][i]) begin
          hi_cnt[k][i]++;
          if (first_hi[k][i] < 0) first_hi[k][i] = cyc_no;
          d_at[k][i] = d_o[k];
        end
      end
    end
  endtask

  // Issue a command and feed words w0+i; optionally withhold one word for
  // gap_len ready cycles (re-issuing start meanwhile), or abort when the
  // given word's enable is seen high.
  task automatic load(input int k, input int b, input int cnt, input logic [31:0] w0,
                      input int gap_word, input int gap_len, input int abort_word,
                      output int n_done);
    int w, n, gap_cnt;
    bit ab_prev;
    w = 0; n = 0; gap_cnt = 0; ab_prev = 1'b0; n_done = -1;
    base_i[k] = 5'(b); count_i[k] = 6'(cnt); start_i[k] = 1'b1;
    cyc();
    n = 1; start_i[k] = 1'b0; start_cyc = cyc_no;
    while (n < 400) begin
      if (ab_prev) chk("abort_en_drop", 64'(en_o[k]), 64'd0);
      abort_i[k] = (abort_word >= 0) && !ab_prev && en_o[k][b + abort_word];
      if (w == gap_word && gap_cnt < gap_len) begin
        valid_i[k] = 1'b0; start_i[k] = 1'b1;
      end else begin
        valid_i[k] = (w < cnt); start_i[k] = 1'b0;
      end
      bits_i[k] = w0 + 32'(w);
      #1;
      if (valid_i[k] && ready_o[k]) w++;
      else if (w == gap_word && ready_o[k] && gap_cnt < gap_len) gap_cnt++;
      ab_prev = abort_i[k];
      cyc();
      n++;
      if (done_o[k]) begin n_done = n; break; end
      if (!busy_o[k]) break;
    end
    valid_i[k] = 1'b0; abort_i[k] = 1'b0; start_i[k] = 1'b0;
    if (n >= 400) begin
      total++; bad++;
      $display("FAIL load_timeout: dut=%0d still busy after %0d cycles", k, n);
    end
  endtask

  initial begin
    int n;
    int guard;
    for (int k = 0; k < 2; k++) begin
      start_i[k] = 1'b0; base_i[k] = '0; count_i[k] = '0;
      abort_i[k] = 1'b0; valid_i[k] = 1'b0; bits_i[k] = '0;
    end
    clear_stats();
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 2; k++) begin
      chk("rst_en", 64'(en_o[k]), 64'd0);
      chk("rst_d", 64'(d_o[k]), 64'd0);
      chk("rst_busy", 64'(busy_o[k]), 64'd0);
      chk("rst_ready", 64'(ready_o[k]), 64'd0);
      chk("rst_done", 64'(done_o[k]), 64'd0);
      chk("rst_err", 64'(err_o[k]), 64'd0);
    end
    cyc();

    // Full bank load with valid held high.
    clear_stats();
    load(0, 0, 17, 32'h1000, -1, 0, -1, n);
    chk("full_done_cycle", 64'(n), 64'd69);
    chk("full_en_mask", 64'(en_mask[0]), 64'h1FFFF);
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("full_en%0d_width", i), 64'(hi_cnt[0][i]), 64'd1);
      chk($sformatf("full_d%0d", i), 64'(d_at[0][i]), 64'(32'h1000 + i));
    end
    cyc();

    // Rejected commands: range overflow and zero count.
    clear_stats();
    base_i[0] = 5'd15; count_i[0] = 6'd3; start_i[0] = 1'b1;
    cyc();
    start_i[0] = 1'b0;
    chk("err_range_pulse", 64'(err_o[0]), 64'd1);
    chk("err_range_busy", 64'(busy_o[0]), 64'd0);
    cyc();
    chk("err_range_clear", 64'(err_o[0]), 64'd0);
    base_i[0] = 5'd4; count_i[0] = 6'd0; start_i[0] = 1'b1;
    cyc();
    start_i[0] = 1'b0;
    chk("err_zero_pulse", 64'(err_o[0]), 64'd1);
    repeat (3) cyc();
    chk("err_no_en", 64'(en_mask[0]), 64'd0);
    chk("err_no_done", 64'(done_cnt[0]), 64'd0);

    // Last word only.
    clear_stats();
    load(0, 16, 1, 32'hA5A5_0000, -1, 0, -1, n);
    chk("last_done_cycle", 64'(n), 64'd5);
    chk("last_en_mask", 64'(en_mask[0]), 64'h10000);
    chk("last_d", 64'(d_at[0][16]), 64'hA5A5_0000);
    cyc();

    // Second word withheld for 10 ready cycles.
    clear_stats();
    load(0, 2, 4, 32'h2000, 1, 10, -1, n);
    chk("gap_done_cycle", 64'(n), 64'd27);
    chk("gap_en3_first", 64'(first_hi[0][3] - start_cyc), 64'd16);
    chk("gap_en2_first", 64'(first_hi[0][2] - start_cyc), 64'd2);
    chk("gap_en_mask", 64'(en_mask[0]), 64'h3C);
    chk("gap_no_err", 64'(err_o[0]), 64'd0);
    cyc();

    // Abort while the second word strobes.
    clear_stats();
    load(0, 5, 3, 32'h3000, -1, 0, 1, n);
    chk("abort_no_done", 64'(done_cnt[0]), 64'd0);
    chk("abort_en_mask", 64'(en_mask[0]), 64'h60);
    chk("abort_d6", 64'(d_at[0][6]), 64'h3001);
    chk("abort_idle", 64'(busy_o[0]), 64'd0);
    repeat (3) cyc();
    chk("abort_en7_never", 64'(hi_cnt[0][7]), 64'd0);

    // Asynchronous reset while en[3] is high.
    base_i[0] = 5'd3; count_i[0] = 6'd2; start_i[0] = 1'b1;
    cyc();
    start_i[0] = 1'b0; valid_i[0] = 1'b1; bits_i[0] = 32'hCAFE_0003;
    guard = 0;
    while (!en_o[0][3] && guard < 20) begin cyc(); guard++; end
    chk("rst_pre_en3", 64'(en_o[0]), 64'h8);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_en", 64'(en_o[0]), 64'd0);
    chk("rst_async_busy", 64'(busy_o[0]), 64'd0);
    valid_i[0] = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();

    // Stretched phases: setup 2, strobe 3, hold 2.
    clear_stats();
    load(1, 0, 3, 32'h4000, -1, 0, -1, n);
    chk("wide_done_cycle", 64'(n), 64'd25);
    chk("wide_setup", 64'(first_hi[1][0] - start_cyc), 64'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("wide_en%0d_width", i), 64'(hi_cnt[1][i]), 64'd3);
    chk("wide_d2", 64'(d_at[1][2]), 64'h4002);
    cyc();

    // Abort and valid together in WAIT: abort wins, word not taken.
    base_i[1] = 5'd0; count_i[1] = 6'd2; start_i[1] = 1'b1;
    cyc();
    start_i[1] = 1'b0; valid_i[1] = 1'b1; abort_i[1] = 1'b1; bits_i[1] = 32'hDEAD_BEEF;
    #1;
    chk("abort_wait_ready", 64'(ready_o[1]), 64'd0);
    cyc();
    valid_i[1] = 1'b0; abort_i[1] = 1'b0;
    chk("abort_wait_busy", 64'(busy_o[1]), 64'd0);
    chk("abort_wait_d", 64'(d_o[1]), 64'h4002);
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
